// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard/forwarding unit:
//   - fwd_sel_e  : operand source select encoding (RF / EX / MEM / WB)
//   - lu_state_e : load-use stall FSM states (RUN / LU_WAIT)
//   - REG_IDX_W  : architectural register index width
//   - stage_hit(): the common "this stage produces the register I read" test
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        RUN     = 1'b0,
        LU_WAIT = 1'b1
    } lu_state_e;

    // A stage hits a source when it writes a non-zero register that the
    // source actually reads. x0 is hard-wired to zero so it never forwards.
    function automatic logic stage_hit(
        input logic                 we,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs,
        input logic                 rf
    );
        return we && (rd != '0) && (rd == rs) && rf;
    endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// ---------------------------------------------------------------------------
// fwd_src_sel
// Forwarding mux for a single ID source operand. Given which pipeline stages
// hit this source, picks the youngest usable value.
// Ports:
//   ex_hit_i, ex_load_i       EX hit and whether EX holds a load
//   mem_hit_i, mem_load_i     MEM hit and whether MEM holds a load
//   mem_ready_i               MEM access has completed (load data valid)
//   wb_hit_i                  WB hit
//   rf_data_i                 register-file read data for this source
//   ex_wd_i/mem_wd_i/wb_wd_i  stage result data
//   sel_o                     chosen source (fwd_sel_e encoding)
//   data_o                    forwarded operand
// ---------------------------------------------------------------------------
module fwd_src_sel
    import hazard_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            ex_hit_i,
    input  logic            ex_load_i,
    input  logic            mem_hit_i,
    input  logic            mem_load_i,
    input  logic            mem_ready_i,
    input  logic            wb_hit_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic [XLEN-1:0] ex_wd_i,
    input  logic [XLEN-1:0] mem_wd_i,
    input  logic [XLEN-1:0] wb_wd_i,
    output logic [1:0]      sel_o,
    output logic [XLEN-1:0] data_o
);

    // Youngest producer wins. A load in EX has no data yet, so it is skipped
    // here and the stall FSM covers it. A load in MEM only becomes a valid
    // source once the memory reports ready; until then an older WB value or
    // the register file is passed through (the pipeline is frozen anyway).
    always_comb begin
        sel_o  = FWD_RF;
        data_o = rf_data_i;
        if (ex_hit_i && !ex_load_i) begin
            sel_o  = FWD_EX;
            data_o = ex_wd_i;
        end else if (mem_hit_i && (!mem_load_i || mem_ready_i)) begin
            sel_o  = FWD_MEM;
            data_o = mem_wd_i;
        end else if (wb_hit_i) begin
            sel_o  = FWD_WB;
            data_o = wb_wd_i;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit_v2.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit_v2
// Data-hazard and forwarding unit for the 5-stage pipeline, beside ID.
// Per-source forwarding muxes plus a registered load-use stall FSM that
// also honours the data-memory ready handshake, optional store-data late
// forwarding, and two saturating performance counters.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   id_valid, id_rs, id_rf, id_rdata ID instruction, sources, RF read data
//   id_store                         ID is a store (src1 = store data)
//   ex_rd/ex_we/ex_load/ex_wd        EX-stage destination info and result
//   mem_rd/mem_we/mem_load/mem_wd    MEM-stage equivalents (load data)
//   mem_ready                        data memory finished the MEM access
//   wb_rd/wb_we/wb_wd                WB-stage write-back
//   fwd_data, fwd_sel                forwarded operands and their source
//   stall_if_id, bubble_ex, freeze   pipeline control
//   store_late_fwd                   store data comes from WB in MEM
//   lu_events, stall_cycles          saturating event/cycle counters
// ---------------------------------------------------------------------------
module hazard_fwd_unit_v2
    import hazard_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_SRC        = 2,
    parameter int STORE_LATE_FWD = 1,
    parameter int PERF_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [NUM_SRC*REG_IDX_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]           id_rf,
    input  logic [NUM_SRC*XLEN-1:0]      id_rdata,
    input  logic                         id_store,
    input  logic [REG_IDX_W-1:0]         ex_rd,
    input  logic                         ex_we,
    input  logic                         ex_load,
    input  logic [XLEN-1:0]              ex_wd,
    input  logic [REG_IDX_W-1:0]         mem_rd,
    input  logic                         mem_we,
    input  logic                         mem_load,
    input  logic [XLEN-1:0]              mem_wd,
    input  logic                         mem_ready,
    input  logic [REG_IDX_W-1:0]         wb_rd,
    input  logic                         wb_we,
    input  logic [XLEN-1:0]              wb_wd,
    output logic [NUM_SRC*XLEN-1:0]      fwd_data,
    output logic [NUM_SRC*2-1:0]         fwd_sel,
    output logic                         stall_if_id,
    output logic                         bubble_ex,
    output logic                         freeze,
    output logic                         store_late_fwd,
    output logic [PERF_W-1:0]            lu_events,
    output logic [PERF_W-1:0]            stall_cycles
);

    // Only src1 (the store data operand) set in a source mask.
    localparam logic [NUM_SRC-1:0] SRC1_MASK = NUM_SRC'(2);

    logic [NUM_SRC-1:0]      exHit;
    logic [NUM_SRC-1:0]      memHit;
    logic [NUM_SRC-1:0]      wbHit;
    logic [NUM_SRC-1:0]      luHitMask;
    logic [NUM_SRC*2-1:0]    srcSel;
    logic [NUM_SRC*XLEN-1:0] srcData;

    logic storeExcl;
    logic luHazard;
    logic storeLate;
    logic freezeRaw;
    logic stallRaw;
    logic bubbleRaw;
    logic luEnter;

    lu_state_e         state_q, state_d;
    logic [PERF_W-1:0] luEvents_q, luEvents_d;
    logic [PERF_W-1:0] stallCycles_q, stallCycles_d;

    // One hit-detector and forwarding mux per source operand.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_IDX_W-1:0] rs;
        assign rs       = id_rs[REG_IDX_W*k +: REG_IDX_W];
        assign exHit[k]  = stage_hit(ex_we,  ex_rd,  rs, id_rf[k]);
        assign memHit[k] = stage_hit(mem_we, mem_rd, rs, id_rf[k]);
        assign wbHit[k]  = stage_hit(wb_we,  wb_rd,  rs, id_rf[k]);

        fwd_src_sel #(
            .XLEN(XLEN)
        ) u_fwd_src_sel (
            .ex_hit_i    (exHit[k]),
            .ex_load_i   (ex_load),
            .mem_hit_i   (memHit[k]),
            .mem_load_i  (mem_load),
            .mem_ready_i (mem_ready),
            .wb_hit_i    (wbHit[k]),
            .rf_data_i   (id_rdata[XLEN*k +: XLEN]),
            .ex_wd_i     (ex_wd),
            .mem_wd_i    (mem_wd),
            .wb_wd_i     (wb_wd),
            .sel_o       (srcSel[2*k +: 2]),
            .data_o      (srcData[XLEN*k +: XLEN])
        );
    end

    // A load in EX feeding any read source is a load-use hazard. A store
    // whose only dependence is its data operand can instead pick the value
    // up from WB once it reaches MEM, so it is allowed through unstalled.
    assign luHitMask = exHit & {NUM_SRC{ex_load}};
    assign storeExcl = (STORE_LATE_FWD != 0) && id_store && (luHitMask == SRC1_MASK);
    assign luHazard  = id_valid && (|luHitMask) && !storeExcl;
    assign storeLate = id_valid && (|luHitMask) && storeExcl;

    // A load still waiting on memory holds the whole pipeline.
    assign freezeRaw = mem_load && mem_we && !mem_ready;

    // Stall FSM. RUN raises the one-cycle load-use stall and moves to
    // LU_WAIT; LU_WAIT keeps stalling until the load in MEM completes, at
    // which point the MEM forwarding path supplies the data. While frozen no
    // bubble is inserted (nothing moves) and the state is held.
    always_comb begin
        state_d   = state_q;
        stallRaw  = 1'b0;
        bubbleRaw = 1'b0;
        luEnter   = 1'b0;
        case (state_q)
            RUN: begin
                if (luHazard) begin
                    stallRaw = 1'b1;
                    if (!freezeRaw) begin
                        bubbleRaw = 1'b1;
                        luEnter   = 1'b1;
                        state_d   = LU_WAIT;
                    end
                end
            end
            LU_WAIT: begin
                if (!mem_ready) begin
                    stallRaw  = 1'b1;
                    bubbleRaw = !freezeRaw;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // Saturating counters: events count entries into the load-use stall,
    // cycles count every cycle the front end is held or the pipe is frozen.
    always_comb begin
        luEvents_d    = luEvents_q;
        stallCycles_d = stallCycles_q;
        if (luEnter && (luEvents_q != '1)) begin
            luEvents_d = luEvents_q + PERF_W'(1);
        end
        if ((stallRaw || freezeRaw) && (stallCycles_q != '1)) begin
            stallCycles_d = stallCycles_q + PERF_W'(1);
        end
    end

    // State and counter registers; reset returns to RUN with cleared counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            luEvents_q    <= '0;
            stallCycles_q <= '0;
        end else begin
            state_q       <= state_d;
            luEvents_q    <= luEvents_d;
            stallCycles_q <= stallCycles_d;
        end
    end

    // Outputs are forced quiet while reset is asserted, independent of the
    // clock, so the pipeline sees plain register-file operands immediately.
    always_comb begin
        stall_if_id    = rst_n && stallRaw;
        bubble_ex      = rst_n && bubbleRaw;
        freeze         = rst_n && freezeRaw;
        store_late_fwd = rst_n && storeLate;
        fwd_sel        = rst_n ? srcSel  : '0;
        fwd_data       = rst_n ? srcData : id_rdata;
    end

    assign lu_events    = luEvents_q;
    assign stall_cycles = stallCycles_q;

endmodule

// File: tb/tb_hazard_fwd_unit_v2.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_unit_v2
// Two instances share all inputs: instance A uses the defaults (late store
// forwarding on, 16-bit counters), instance B disables late forwarding and
// uses 4-bit counters so saturation is reachable. Expected values come from
// a behavioural model of the hazard rules kept in this file.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_unit_v2;

    logic        clk;
    logic        rstN;
    logic        idValid;
    logic [9:0]  idRs;
    logic [1:0]  idRf;
    logic [63:0] idRdata;
    logic        idStore;
    logic [4:0]  exRd;
    logic        exWe;
    logic        exLoad;
    logic [31:0] exWd;
    logic [4:0]  memRd;
    logic        memWe;
    logic        memLoad;
    logic [31:0] memWd;
    logic        memReady;
    logic [4:0]  wbRd;
    logic        wbWe;
    logic [31:0] wbWd;

    logic [63:0] fwdDataA, fwdDataB;
    logic [3:0]  fwdSelA, fwdSelB;
    logic        stallA, stallB, bubbleA, bubbleB, freezeA, freezeB, lateA, lateB;
    logic [15:0] luA, scA;
    logic [3:0]  luB, scB;

    int checks = 0;
    int errors = 0;

    // Behavioural model state, index 0 = instance A, 1 = instance B.
    bit          mWait[2];
    int          mLu[2];
    int          mSc[2];
    int          cntMax[2] = '{65535, 15};

    logic [1:0]  expSel[2];
    logic [31:0] expData[2];
    logic        expFreeze;
    logic        expStall[2];
    logic        expBubble[2];
    logic        expLate[2];
    logic        expEnter[2];
    logic        expCount[2];
    bit          expNextWait[2];

    hazard_fwd_unit_v2 u_dutA (
        .clk(clk), .rst_n(rstN), .id_valid(idValid), .id_rs(idRs), .id_rf(idRf),
        .id_rdata(idRdata), .id_store(idStore), .ex_rd(exRd), .ex_we(exWe),
        .ex_load(exLoad), .ex_wd(exWd), .mem_rd(memRd), .mem_we(memWe),
        .mem_load(memLoad), .mem_wd(memWd), .mem_ready(memReady), .wb_rd(wbRd),
        .wb_we(wbWe), .wb_wd(wbWd), .fwd_data(fwdDataA), .fwd_sel(fwdSelA),
        .stall_if_id(stallA), .bubble_ex(bubbleA), .freeze(freezeA),
        .store_late_fwd(lateA), .lu_events(luA), .stall_cycles(scA)
    );

    hazard_fwd_unit_v2 #(
        .STORE_LATE_FWD(0),
        .PERF_W(4)
    ) u_dutB (
        .clk(clk), .rst_n(rstN), .id_valid(idValid), .id_rs(idRs), .id_rf(idRf),
        .id_rdata(idRdata), .id_store(idStore), .ex_rd(exRd), .ex_we(exWe),
        .ex_load(exLoad), .ex_wd(exWd), .mem_rd(memRd), .mem_we(memWe),
        .mem_load(memLoad), .mem_wd(memWd), .mem_ready(memReady), .wb_rd(wbRd),
        .wb_we(wbWe), .wb_wd(wbWd), .fwd_data(fwdDataB), .fwd_sel(fwdSelB),
        .stall_if_id(stallB), .bubble_ex(bubbleB), .freeze(freezeB),
        .store_late_fwd(lateB), .lu_events(luB), .stall_cycles(scB)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic hitRule(input logic we, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic rf);
        return we && (rd != 5'd0) && (rd == rs) && rf;
    endfunction

    // Derive the expected combinational behaviour from the current inputs
    // and the model's idea of whether a load-use stall is outstanding.
    task automatic evalModel();
        logic [4:0] rs;
        logic [1:0] luMask;
        logic       anyLu, freezeRaw, excl, haz;
        for (int k = 0; k < 2; k++) begin
            rs         = idRs[5*k +: 5];
            expSel[k]  = 2'd0;
            expData[k] = idRdata[32*k +: 32];
            if (rstN) begin
                if (hitRule(exWe, exRd, rs, idRf[k]) && !exLoad) begin
                    expSel[k] = 2'd1; expData[k] = exWd;
                end else if (hitRule(memWe, memRd, rs, idRf[k]) && (!memLoad || memReady)) begin
                    expSel[k] = 2'd2; expData[k] = memWd;
                end else if (hitRule(wbWe, wbRd, rs, idRf[k])) begin
                    expSel[k] = 2'd3; expData[k] = wbWd;
                end
            end
            luMask[k] = hitRule(exWe, exRd, rs, idRf[k]) && exLoad;
        end
        anyLu     = idValid && (luMask != 2'b00);
        freezeRaw = memLoad && memWe && !memReady;
        expFreeze = rstN && freezeRaw;
        for (int i = 0; i < 2; i++) begin
            // Only instance A has late store forwarding enabled.
            excl       = (i == 0) && idStore && (luMask == 2'b10);
            haz        = anyLu && !excl;
            expLate[i] = rstN && anyLu && excl;
            if (mWait[i]) begin
                expStall[i]  = !memReady;
                expBubble[i] = !memReady && !freezeRaw;
                expEnter[i]  = 1'b0;
            end else begin
                expStall[i]  = haz;
                expBubble[i] = haz && !freezeRaw;
                expEnter[i]  = haz && !freezeRaw;
            end
            if (!rstN) begin
                expStall[i]  = 1'b0;
                expBubble[i] = 1'b0;
                expEnter[i]  = 1'b0;
            end
            expNextWait[i] = mWait[i] ? !memReady : expEnter[i];
            expCount[i]    = expStall[i] || expFreeze;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mWait[i] = 1'b0; mLu[i] = 0; mSc[i] = 0;
        end
    endtask

    // Advance one clock and the model alongside it; returns 1 unit after
    // the edge so registered outputs have settled.
    task automatic tick();
        evalModel();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rstN) begin
                mWait[i] = 1'b0; mLu[i] = 0; mSc[i] = 0;
            end else begin
                if (expEnter[i] && mLu[i] < cntMax[i]) mLu[i]++;
                if (expCount[i] && mSc[i] < cntMax[i]) mSc[i]++;
                mWait[i] = expNextWait[i];
            end
        end
        #1;
    endtask

    task automatic setIdle();
        idValid = 0; idRs = '0; idRf = '0; idStore = 0;
        idRdata = 64'hAAAA_BBBB_CCCC_DDDD;
        exRd = '0; exWe = 0; exLoad = 0; exWd = '0;
        memRd = '0; memWe = 0; memLoad = 0; memWd = '0; memReady = 1;
        wbRd = '0; wbWe = 0; wbWd = '0;
    endtask

    task automatic doReset();
        setIdle();
        rstN = 0;
        #1;
        modelReset();
        tick();
        rstN = 1;
        #1;
    endtask

    // EX holds "lw x6"; ID reads x6 on src0.
    task automatic driveLoadUse(input logic [31:0] loadData);
        setIdle();
        idValid = 1; idRs = {5'd0, 5'd6}; idRf = 2'b11;
        exWe = 1; exRd = 5'd6; exLoad = 1; exWd = loadData;
    endtask

    // The load has moved to MEM; ID still holds the dependent instruction.
    task automatic driveLoadInMem(input logic [31:0] loadData, input logic ready);
        exWe = 0; exLoad = 0; exRd = '0;
        memWe = 1; memRd = 5'd6; memLoad = 1; memWd = loadData; memReady = ready;
    endtask

    task automatic test_reset();
        setIdle();
        rstN = 0;
        driveLoadUse(32'h1);
        memWe = 1; memLoad = 1; memRd = 5'd2; memReady = 0;
        #1;
        checks++;
        if (stallA !== 1'b0 || bubbleA !== 1'b0 || freezeA !== 1'b0 || lateA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got stall=%b bubble=%b freeze=%b late=%b expected all 0",
                     stallA, bubbleA, freezeA, lateA);
        end
        checks++;
        if (fwdSelA !== 4'h0 || fwdDataA !== idRdata) begin
            errors++;
            $display("[TB] FAIL reset_fwd: got sel=%h data=%h expected sel=0 data=%h",
                     fwdSelA, fwdDataA, idRdata);
        end
        modelReset();
        tick();
        checks++;
        if (luA !== 16'd0 || scA !== 16'd0 || luB !== 4'd0 || scB !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got %0d/%0d/%0d/%0d expected 0",
                     luA, scA, luB, scB);
        end
        setIdle();
        rstN = 1;
        #1;
    endtask

    task automatic test_back_to_back();
        doReset();
        idValid = 1; idRs = {5'd5, 5'd5}; idRf = 2'b11;
        exWe = 1; exRd = 5'd5; exWd = 32'h10;
        #1;
        checks++;
        if (fwdSelA !== 4'b0101 || fwdDataA !== 64'h0000_0010_0000_0010) begin
            errors++;
            $display("[TB] FAIL b2b_fwd: got sel=%h data=%h expected sel=5 data=0000001000000010",
                     fwdSelA, fwdDataA);
        end
        checks++;
        if (stallA !== 1'b0 || bubbleA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_nostall: got stall=%b bubble=%b expected 0 0", stallA, bubbleA);
        end
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        driveLoadUse(32'hDEAD);
        #1;
        checks++;
        if (stallA !== 1'b1 || bubbleA !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lu_enter: got stall=%b bubble=%b expected 1 1", stallA, bubbleA);
        end
        tick();
        checks++;
        if (luA !== 16'd1) begin
            errors++;
            $display("[TB] FAIL lu_events: got %0d expected 1", luA);
        end
        driveLoadInMem(32'hCAFE, 1'b1);
        #1;
        checks++;
        if (fwdSelA[1:0] !== 2'd2 || fwdDataA[31:0] !== 32'hCAFE || stallA !== 1'b0 || bubbleA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lu_release: got sel=%0d data=%h stall=%b bubble=%b expected 2 cafe 0 0",
                     fwdSelA[1:0], fwdDataA[31:0], stallA, bubbleA);
        end
        tick();
        setIdle();
        #1;
    endtask

    task automatic test_slow_mem();
        doReset();
        driveLoadUse(32'h0);
        tick();
        for (int c = 0; c < 2; c++) begin
            driveLoadInMem(32'h1234_5678, 1'b0);
            #1;
            checks++;
            if (freezeA !== 1'b1 || stallA !== 1'b1 || bubbleA !== 1'b0) begin
                errors++;
                $display("[TB] FAIL slow_wait%0d: got freeze=%b stall=%b bubble=%b expected 1 1 0",
                         c, freezeA, stallA, bubbleA);
            end
            tick();
        end
        driveLoadInMem(32'h1234_5678, 1'b1);
        #1;
        checks++;
        if (fwdDataA[31:0] !== 32'h1234_5678 || stallA !== 1'b0 || freezeA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL slow_release: got data=%h stall=%b freeze=%b expected 12345678 0 0",
                     fwdDataA[31:0], stallA, freezeA);
        end
        tick();
        checks++;
        if (scA !== 16'd3 || luA !== 16'd1 || scB !== 4'd3) begin
            errors++;
            $display("[TB] FAIL slow_counters: got sc=%0d lu=%0d scB=%0d expected 3 1 3", scA, luA, scB);
        end
        setIdle();
        #1;
    endtask

    task automatic test_store_late();
        doReset();
        // sw x8,0(x9): src0 = base x9, src1 = data x8; lw x8 in EX
        idValid = 1; idStore = 1; idRs = {5'd8, 5'd9}; idRf = 2'b11;
        exWe = 1; exRd = 5'd8; exLoad = 1;
        #1;
        checks++;
        if (stallA !== 1'b0 || lateA !== 1'b1 || fwdSelA[1:0] !== 2'd0) begin
            errors++;
            $display("[TB] FAIL store_late_on: got stall=%b late=%b sel0=%0d expected 0 1 0",
                     stallA, lateA, fwdSelA[1:0]);
        end
        checks++;
        if (stallB !== 1'b1 || bubbleB !== 1'b1 || lateB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL store_late_off: got stall=%b bubble=%b late=%b expected 1 1 0",
                     stallB, bubbleB, lateB);
        end
        tick();
        exWe = 0; exLoad = 0; exRd = '0;
        memWe = 1; memRd = 5'd8; memLoad = 1; memWd = 32'h55; memReady = 1;
        #1;
        checks++;
        if (stallB !== 1'b0 || stallA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL store_release: got stallA=%b stallB=%b expected 0 0", stallA, stallB);
        end
        tick();
        checks++;
        if (luA !== 16'd0 || luB !== 4'd1 || scB !== 4'd1) begin
            errors++;
            $display("[TB] FAIL store_counters: got luA=%0d luB=%0d scB=%0d expected 0 1 1",
                     luA, luB, scB);
        end
        setIdle();
        #1;
    endtask

    task automatic test_priority_x0();
        doReset();
        idValid = 1; idRs = {5'd3, 5'd3}; idRf = 2'b11;
        exWe = 1;  exRd = 5'd3;  exWd = 32'd1;
        memWe = 1; memRd = 5'd3; memWd = 32'd2;
        wbWe = 1;  wbRd = 5'd3;  wbWd = 32'd3;
        #1;
        checks++;
        if (fwdSelA !== 4'b0101 || fwdDataA !== 64'h0000_0001_0000_0001) begin
            errors++;
            $display("[TB] FAIL prio_ex: got sel=%h data=%h expected 5 0000000100000001", fwdSelA, fwdDataA);
        end
        exWe = 0;
        #1;
        checks++;
        if (fwdSelA !== 4'b1010 || fwdDataA !== 64'h0000_0002_0000_0002) begin
            errors++;
            $display("[TB] FAIL prio_mem: got sel=%h data=%h expected a 0000000200000002", fwdSelA, fwdDataA);
        end
        memLoad = 1; memReady = 0;
        #1;
        checks++;
        if (fwdSelA !== 4'b1111 || fwdDataA !== 64'h0000_0003_0000_0003 || freezeA !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_wb_memwait: got sel=%h data=%h freeze=%b expected f 0000000300000003 1",
                     fwdSelA, fwdDataA, freezeA);
        end
        memLoad = 0; memReady = 1; exWe = 1;
        exRd = 5'd0; memRd = 5'd0; wbRd = 5'd0; idRs = '0;
        #1;
        checks++;
        if (fwdSelA !== 4'b0000 || fwdDataA !== idRdata) begin
            errors++;
            $display("[TB] FAIL x0_noforward: got sel=%h data=%h expected 0 %h", fwdSelA, fwdDataA, idRdata);
        end
        tick();
        setIdle();
        #1;
    endtask

    task automatic test_saturation();
        doReset();
        idValid = 1; idRs = {5'd0, 5'd4}; idRf = 2'b01;
        exWe = 1; exRd = 5'd4; exLoad = 1; memReady = 1;
        repeat (40) tick();
        checks++;
        if (luB !== 4'd15 || scB !== 4'd15) begin
            errors++;
            $display("[TB] FAIL sat_small: got lu=%0d sc=%0d expected 15 15", luB, scB);
        end
        checks++;
        if (luA !== 16'd20 || scA !== 16'd20) begin
            errors++;
            $display("[TB] FAIL sat_wide: got lu=%0d sc=%0d expected 20 20", luA, scA);
        end
        setIdle();
        #1;
    endtask

    task automatic test_random();
        doReset();
        for (int n = 0; n < 400; n++) begin
            idValid  = $urandom_range(0, 1);
            idRs     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            idRf     = 2'($urandom_range(0, 3));
            idStore  = ($urandom_range(0, 3) == 0);
            idRdata  = {$urandom, $urandom};
            exRd     = 5'($urandom_range(0, 3));
            exWe     = $urandom_range(0, 1);
            exLoad   = $urandom_range(0, 1);
            exWd     = $urandom;
            memRd    = 5'($urandom_range(0, 3));
            memWe    = $urandom_range(0, 1);
            memLoad  = $urandom_range(0, 1);
            memWd    = $urandom;
            memReady = ($urandom_range(0, 3) != 0);
            wbRd     = 5'($urandom_range(0, 3));
            wbWe     = $urandom_range(0, 1);
            wbWd     = $urandom;
            #1;
            evalModel();
            checks++;
            if (fwdSelA !== {expSel[1], expSel[0]} || fwdDataA !== {expData[1], expData[0]} ||
                fwdSelB !== {expSel[1], expSel[0]} || fwdDataB !== {expData[1], expData[0]}) begin
                errors++;
                $display("[TB] FAIL rnd_fwd[%0d]: got selA=%h dataA=%h selB=%h expected sel=%h data=%h",
                         n, fwdSelA, fwdDataA, fwdSelB, {expSel[1], expSel[0]}, {expData[1], expData[0]});
            end
            checks++;
            if (stallA !== expStall[0] || bubbleA !== expBubble[0] || freezeA !== expFreeze ||
                lateA !== expLate[0]) begin
                errors++;
                $display("[TB] FAIL rnd_ctrlA[%0d]: got s/b/f/l=%b%b%b%b expected %b%b%b%b", n,
                         stallA, bubbleA, freezeA, lateA, expStall[0], expBubble[0], expFreeze, expLate[0]);
            end
            checks++;
            if (stallB !== expStall[1] || bubbleB !== expBubble[1] || freezeB !== expFreeze ||
                lateB !== expLate[1]) begin
                errors++;
                $display("[TB] FAIL rnd_ctrlB[%0d]: got s/b/f/l=%b%b%b%b expected %b%b%b%b", n,
                         stallB, bubbleB, freezeB, lateB, expStall[1], expBubble[1], expFreeze, expLate[1]);
            end
            tick();
            checks++;
            if (luA !== 16'(mLu[0]) || scA !== 16'(mSc[0]) || luB !== 4'(mLu[1]) || scB !== 4'(mSc[1])) begin
                errors++;
                $display("[TB] FAIL rnd_counters[%0d]: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", n,
                         luA, scA, luB, scB, mLu[0], mSc[0], mLu[1], mSc[1]);
            end
        end
        setIdle();
        #1;
    endtask

    task automatic test_reset_mid_stall();
        doReset();
        driveLoadUse(32'h0);
        tick();
        driveLoadInMem(32'h77, 1'b0);
        #2;
        rstN = 0;
        #1;
        modelReset();
        checks++;
        if (stallA !== 1'b0 || bubbleA !== 1'b0 || freezeA !== 1'b0 || fwdSelA !== 4'h0 ||
            fwdDataA !== idRdata) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got stall=%b bubble=%b freeze=%b sel=%h data=%h expected 0 0 0 0 %h",
                     stallA, bubbleA, freezeA, fwdSelA, fwdDataA, idRdata);
        end
        checks++;
        if (luA !== 16'd0 || scA !== 16'd0 || luB !== 4'd0 || scB !== 4'd0) begin
            errors++;
            $display("[TB] FAIL midreset_counters: got %0d/%0d/%0d/%0d expected 0", luA, scA, luB, scB);
        end
        tick();
        setIdle();
        memReady = 0;
        rstN = 1;
        #1;
        checks++;
        if (stallA !== 1'b0 || stallB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_state_run: got stallA=%b stallB=%b expected 0 0", stallA, stallB);
        end
        tick();
        setIdle();
        #1;
    endtask

    // Run every scenario in order, then report.
    initial begin
        rstN = 0;
        setIdle();
        modelReset();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_slow_mem();
        test_store_late();
        test_priority_x0();
        test_saturation();
        test_random();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
